// File: rtl/xor_cipher_ctrl.sv
// XOR cipher sequencer: loads a key from the first received bytes, then ciphers and queues
// later bytes for the UART transmitter. Define XOR_CIPHER_KEYCMD_EN for in-band key reload.
module xor_cipher_ctrl #(
  parameter int unsigned KEY_LEN  = 4,
  parameter int unsigned FIFO_AW  = 3,
  parameter logic [7:0]  CMD_BYTE = 8'h1B
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_done_tick_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_done_tick_i,
  input  logic       key_reload_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       key_ready_o,
  output logic       fifo_full_o,
  output logic       overflow_o
);

  localparam int unsigned IdxW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned PtrW = FIFO_AW + 1;
`ifdef XOR_CIPHER_KEYCMD_EN
  localparam bit KeyCmdEn = 1'b1;
`else
  localparam bit KeyCmdEn = 1'b0;
`endif

  typedef enum logic {StLoadKey, StRun} rx_state_e;
  typedef enum logic {StTxIdle, StTxWait} tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic [7:0]      key_q [KEY_LEN];
  logic [IdxW-1:0] key_idx_q, key_idx_d;
  logic            key_we;

  logic [7:0]      mem_q [2**FIFO_AW];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            push, pop, fifo_empty, fifo_full;
  logic [7:0]      push_data;

  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overflow_q, overflow_d;
  logic       cmd_hit;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push_data  = rx_data_i ^ key_q[key_idx_q];
  assign cmd_hit    = KeyCmdEn && (rx_data_i == CMD_BYTE);

  // Receive side: key loading and ciphering; reload has priority over a received byte
  always_comb begin
    rx_state_d = rx_state_q;
    key_idx_d  = key_idx_q;
    key_we     = 1'b0;
    push       = 1'b0;
    overflow_d = overflow_q;
    if (key_reload_i) begin
      rx_state_d = StLoadKey;
      key_idx_d  = '0;
    end else if (rx_done_tick_i) begin
      unique case (rx_state_q)
        StLoadKey: begin
          key_we = 1'b1;
          if (key_idx_q == IdxW'(KEY_LEN - 1)) begin
            key_idx_d  = '0;
            rx_state_d = StRun;
          end else begin
            key_idx_d = key_idx_q + IdxW'(1);
          end
        end
        StRun: begin
          if (cmd_hit) begin
            rx_state_d = StLoadKey;
            key_idx_d  = '0;
          end else if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            push      = 1'b1;
            key_idx_d = (key_idx_q == IdxW'(KEY_LEN - 1)) ? '0 : key_idx_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      StTxIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
          tx_start_d = 1'b1;
          tx_state_d = StTxWait;
        end
      end
      StTxWait: begin
        if (tx_done_tick_i) tx_state_d = StTxIdle;
      end
      default: ;
    endcase
  end

  assign wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_q <= StLoadKey;
      tx_state_q <= StTxIdle;
      key_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      key_idx_q  <= key_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      if (key_we) key_q[key_idx_q] <= rx_data_i;
    end
  end

  // Storage needs no reset: pointers alone define validity
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign key_ready_o = (rx_state_q == StRun);
  assign fifo_full_o = fifo_full;
  assign overflow_o  = overflow_q;

endmodule
